// File: rtl/as1802_mem_bridge.sv
// AS1802 memory bridge: demultiplexes the core's time-multiplexed address bus and
// turns MRD/MWR strobe edges into single-cycle synchronous RAM requests.
module as1802_mem_bridge #(
  parameter int         RD_LAT   = 1,
  parameter logic [7:0] HI_RESET = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic [7:0]       cpu_addr,
  input  logic [7:0]       cpu_dout,
  input  logic             cpu_mrd_n,
  input  logic             cpu_mwr_n,
  input  logic             cpu_tpa,
  input  logic [1:0]       cpu_sc,
  output logic [7:0]       cpu_din,
  output logic             ram_en,
  output logic             ram_we,
  output logic [15:0]      ram_addr,
  output logic [7:0]       ram_wdata,
  input  logic [7:0]       ram_rdata,
  output logic             busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: ram_en is a one-cycle request; ram_we, ram_addr and ram_wdata are
  // meaningful only while ram_en=1. Read data is taken RD_LAT cycles after ram_en.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_DONE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t      state, state_d;
  logic        tpa_q, mrd_q, mwr_q;
  logic [7:0]  addr_hi;
  logic [1:0]  lat_cnt;
  logic        fetch_q;
  logic        rd_fall, wr_fall, tpa_rise;
  logic        issue_rd, issue_wr, capture, err_set;

  // Previous-value registers reset to 0 so a strobe held low through reset is
  // not mistaken for a fresh falling edge.
  assign rd_fall  = mrd_q & ~cpu_mrd_n;
  assign wr_fall  = mwr_q & ~cpu_mwr_n;
  assign tpa_rise = cpu_tpa & ~tpa_q;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_d  = state;
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    capture  = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (rd_fall || wr_fall) begin
          if (!cpu_mrd_n && !cpu_mwr_n) begin
            err_set = 1'b1;
            state_d = HOLD;
          end else if (rd_fall) begin
            issue_rd = 1'b1;
            state_d  = RD_WAIT;
          end else begin
            issue_wr = 1'b1;
            state_d  = WR_DONE;
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt == 2'd0) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      WR_DONE: state_d = HOLD;
      HOLD: begin
        if (cpu_mrd_n && cpu_mwr_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state != IDLE && (rd_fall || wr_fall)) err_set = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tpa_q     <= 1'b0;
      mrd_q     <= 1'b0;
      mwr_q     <= 1'b0;
      addr_hi   <= HI_RESET;
      lat_cnt   <= 2'd0;
      fetch_q   <= 1'b0;
      cpu_din   <= 8'h00;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= {HI_RESET, 8'h00};
      ram_wdata <= 8'h00;
      proto_err <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state  <= state_d;
      tpa_q  <= cpu_tpa;
      mrd_q  <= cpu_mrd_n;
      mwr_q  <= cpu_mwr_n;
      ram_en <= issue_rd | issue_wr;
      ram_we <= issue_wr;
      if (tpa_rise) addr_hi <= cpu_addr;
      if (issue_rd || issue_wr) ram_addr <= {addr_hi, cpu_addr};
      if (issue_wr) ram_wdata <= cpu_dout;
      if (issue_rd) begin
        lat_cnt <= 2'(RD_LAT);
        fetch_q <= (cpu_sc == 2'b00);
      end else if (state == RD_WAIT && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (capture) begin
        cpu_din <= ram_rdata;
        if (fetch_q && fetch_cnt != '1) fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
      if (err_set) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_as1802_mem_bridge.sv
// Directed bench for as1802_mem_bridge: reset, read, write, strobe conflict,
// reset mid-access and fetch counter saturation with a 4-bit counter.
module tb_as1802_mem_bridge;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [7:0]       cpu_addr;
  logic [7:0]       cpu_dout;
  logic             cpu_mrd_n;
  logic             cpu_mwr_n;
  logic             cpu_tpa;
  logic [1:0]       cpu_sc;
  logic [7:0]       cpu_din;
  logic             ram_en;
  logic             ram_we;
  logic [15:0]      ram_addr;
  logic [7:0]       ram_wdata;
  logic [7:0]       ram_rdata;
  logic             busy;
  logic             proto_err;
  logic [CNT_W-1:0] fetch_cnt;
  logic [1:0]       dbg_state;

  int         errors = 0;
  int         checks = 0;
  int         en_cnt = 0;
  logic [7:0] exp_din;

  as1802_mem_bridge #(
    .RD_LAT   (1),
    .HI_RESET (8'hC3),
    .CNT_W    (CNT_W)
  ) dut (
    .wb_clk_i  (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_mrd_n (cpu_mrd_n),
    .cpu_mwr_n (cpu_mwr_n),
    .cpu_tpa   (cpu_tpa),
    .cpu_sc    (cpu_sc),
    .cpu_din   (cpu_din),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .proto_err (proto_err),
    .fetch_cnt (fetch_cnt),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts RAM request cycles, sampled mid-cycle
  always @(negedge clk) if (ram_en) en_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: TPA cycle for the high byte, then MRD falls with the low byte
  task automatic do_read(input logic [7:0] hi, input logic [7:0] lo,
                         input logic [1:0] sc, input logic [7:0] data);
    int base;
    ram_rdata = ~data;
    cpu_tpa   = 1'b1;
    cpu_addr  = hi;
    tick();
    cpu_tpa   = 1'b0;
    cpu_addr  = lo;
    cpu_sc    = sc;
    cpu_mrd_n = 1'b0;
    base      = en_cnt;
    tick();
    check("rd_en", 32'(ram_en), 32'd1);
    check("rd_we", 32'(ram_we), 32'd0);
    check("rd_addr", 32'(ram_addr), 32'({hi, lo}));
    tick();
    ram_rdata = data;
    check("rd_pulse_len", 32'(ram_en), 32'd0);
    check("rd_din_early", 32'(cpu_din), 32'(exp_din));
    tick();
    ram_rdata = ~data;
    exp_din   = data;
    check("rd_din", 32'(cpu_din), 32'(exp_din));
    cpu_mrd_n = 1'b1;
    tick();
    check("rd_idle", 32'(busy), 32'd0);
    check("rd_pulses", 32'(en_cnt - base), 32'd1);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    cpu_addr  = 8'h00;
    cpu_dout  = 8'h00;
    cpu_mrd_n = 1'b1;
    cpu_mwr_n = 1'b1;
    cpu_tpa   = 1'b0;
    cpu_sc    = 2'b00;
    ram_rdata = 8'h00;
    exp_din   = 8'h00;
    repeat (3) tick();

    // Reset values
    check("rst_din", 32'(cpu_din), 32'h00);
    check("rst_en", 32'(ram_en), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'hC300);
    check("rst_wdata", 32'(ram_wdata), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(proto_err), 32'd0);
    check("rst_fetch", 32'(fetch_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_no_pulse", 32'(en_cnt), 32'd0);

    // Fetch read 0x1234 -> A5
    do_read(8'h12, 8'h34, 2'b00, 8'hA5);
    check("rd_fetch", 32'(fetch_cnt), 32'd1);

    // Write 0xFFFE <- 5A with MWR low for 4 samples
    cpu_tpa  = 1'b1;
    cpu_addr = 8'hFF;
    tick();
    cpu_tpa   = 1'b0;
    cpu_addr  = 8'hFE;
    cpu_dout  = 8'h5A;
    cpu_mwr_n = 1'b0;
    base      = en_cnt;
    tick();
    check("wr_en", 32'(ram_en), 32'd1);
    check("wr_we", 32'(ram_we), 32'd1);
    check("wr_addr", 32'(ram_addr), 32'hFFFE);
    check("wr_data", 32'(ram_wdata), 32'h5A);
    repeat (3) tick();
    check("wr_hold_busy", 32'(busy), 32'd1);
    check("wr_hold_state", 32'(dbg_state), 32'd3);
    cpu_mwr_n = 1'b1;
    tick();
    check("wr_idle", 32'(busy), 32'd0);
    check("wr_pulses", 32'(en_cnt - base), 32'd1);
    check("wr_din_kept", 32'(cpu_din), 32'(exp_din));
    check("wr_addr_kept", 32'(ram_addr), 32'hFFFE);
    check("wr_fetch_kept", 32'(fetch_cnt), 32'd1);

    // Execute-cycle read never counts; then 20 fetch reads saturate at F
    do_read(8'h20, 8'h00, 2'b01, 8'h11);
    check("exec_no_count", 32'(fetch_cnt), 32'd1);
    for (int i = 0; i < 5; i++) do_read(8'h30, 8'(i), 2'b00, 8'(8'h60 + i));
    check("fetch_6", 32'(fetch_cnt), 32'd6);
    for (int i = 0; i < 15; i++) do_read(8'hFF, 8'(8'hF0 + i), 2'b00, 8'(8'h80 + i));
    check("fetch_sat", 32'(fetch_cnt), 32'hF);
    check("no_err_yet", 32'(proto_err), 32'd0);

    // Conflict: both strobes fall on the same sample
    cpu_mrd_n = 1'b0;
    cpu_mwr_n = 1'b0;
    base      = en_cnt;
    tick();
    check("cf_err", 32'(proto_err), 32'd1);
    check("cf_busy", 32'(busy), 32'd1);
    repeat (2) tick();
    cpu_mrd_n = 1'b1;
    cpu_mwr_n = 1'b1;
    tick();
    check("cf_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    check("cf_no_pulse", 32'(en_cnt - base), 32'd0);
    check("cf_sticky", 32'(proto_err), 32'd1);

    // Reset during RD_WAIT
    cpu_tpa  = 1'b1;
    cpu_addr = 8'h55;
    tick();
    cpu_tpa   = 1'b0;
    cpu_addr  = 8'h66;
    cpu_mrd_n = 1'b0;
    tick();
    check("mid_en", 32'(ram_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_state", 32'(dbg_state), 32'd0);
    check("mid_en_clr", 32'(ram_en), 32'd0);
    check("mid_err_clr", 32'(proto_err), 32'd0);
    check("mid_fetch_clr", 32'(fetch_cnt), 32'd0);
    ram_rdata = 8'hEE;
    cpu_mrd_n = 1'b1;
    repeat (2) tick();
    exp_din = 8'h00;
    check("mid_din", 32'(cpu_din), 32'h00);
    rst_n = 1'b1;
    tick();
    do_read(8'hAB, 8'hCD, 2'b00, 8'h77);
    check("post_rst_fetch", 32'(fetch_cnt), 32'd1);

    // Strobe released in RD_WAIT and falling again: read completes, error flagged
    cpu_tpa  = 1'b1;
    cpu_addr = 8'h40;
    tick();
    cpu_tpa   = 1'b0;
    cpu_addr  = 8'h41;
    cpu_sc    = 2'b01;
    cpu_mrd_n = 1'b0;
    base      = en_cnt;
    tick();
    check("rel_no_err", 32'(proto_err), 32'd0);
    cpu_mrd_n = 1'b1;
    tick();
    ram_rdata = 8'h3C;
    cpu_mrd_n = 1'b0;
    tick();
    check("rel_din", 32'(cpu_din), 32'h3C);
    check("rel_err", 32'(proto_err), 32'd1);
    cpu_mrd_n = 1'b1;
    tick();
    check("rel_idle", 32'(busy), 32'd0);
    check("rel_pulses", 32'(en_cnt - base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
